mem_mmio_router: RTL and testbench

- Single-outstanding request router between the core's data-memory port and two targets: main memory and one MMIO device window.
- Classifies each request by address using an inclusive range check: DEV_BASE <= addr <= DEV_LAST selects the device; any other address selects memory.
- Forwards the request, waits for the selected target's response, and returns a one-cycle response upstream.
- Converts target non-response into an error response using a watchdog counter.

---
 rtl/mem_mmio_router.sv | 159 +++++++++++++++
 tb/tb_mem_mmio_router.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_mmio_router.sv
// rtl/mem_mmio_router.sv - single-outstanding request router to main memory or one MMIO device window
//
// Optional feature macro: MMIO_ROUTER_ALIGN_CHECK_EN
//   defined   : requests with addr[1:0] != 0 get an immediate error response and are never forwarded
//   undefined : the full address is forwarded unchanged
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req_valid/req_ready/req_addr/
//   req_wen/req_wdata                  upstream request (accepted in IDLE)
//   resp_valid/resp_error/resp_rdata   one-cycle upstream response; error/rdata held until next response
//   out_addr/out_wen/out_wdata         latched request shared by both targets
//   mem_valid/mem_ready                request handshake to memory
//   mem_resp_valid/mem_resp_rdata      memory response / write-ack
//   dev_valid/dev_ready                request handshake to the device
//   dev_resp_valid/dev_resp_rdata      device response / write-ack
module mem_mmio_router #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] DEV_BASE = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] DEV_LAST = 32'h1000_0FFF,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_error,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_wen,
  output logic [31:0]       out_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  output logic              dev_valid,
  input  logic              dev_ready,
  input  logic              dev_resp_valid,
  input  logic [31:0]       dev_resp_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             sel_dev;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_inc;
  logic             wd_expired;
  logic             in_dev;
  logic             misaligned;
  logic             tgt_ready;
  logic             tgt_resp;
  logic [31:0]      tgt_rdata;

  assign in_dev = (req_addr >= DEV_BASE) && (req_addr <= DEV_LAST);

`ifdef MMIO_ROUTER_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Only the selected target's handshake and response are ever looked at,
  // which is what makes stray responses from the other target harmless.
  assign tgt_ready = sel_dev ? dev_ready      : mem_ready;
  assign tgt_resp  = sel_dev ? dev_resp_valid : mem_resp_valid;
  assign tgt_rdata = sel_dev ? dev_resp_rdata : mem_resp_rdata;

  // wd_inc is the count including the current WAIT cycle; reaching TIMEOUT
  // means TIMEOUT cycles have been spent in WAIT. Saturates, never wraps.
  assign wd_inc     = (wd_cnt == CNT_W'(TIMEOUT)) ? wd_cnt : wd_cnt + 1'b1;
  assign wd_expired = (wd_inc == CNT_W'(TIMEOUT));

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    dev_valid  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = misaligned ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_valid = ~sel_dev;
        dev_valid = sel_dev;
        if (tgt_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (tgt_resp || wd_expired) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset drops every handshake in the same cycle so an in-flight
    // transaction is abandoned immediately.
    if (reset) begin
      req_ready  = 1'b0;
      mem_valid  = 1'b0;
      dev_valid  = 1'b0;
      resp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel_dev    <= 1'b0;
      wd_cnt     <= '0;
      out_addr   <= '0;
      out_wen    <= 1'b0;
      out_wdata  <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            out_addr  <= req_addr;
            out_wen   <= req_wen;
            out_wdata <= req_wdata;
            sel_dev   <= in_dev;
            if (misaligned) begin
              resp_rdata <= '0;
              resp_error <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (tgt_ready) wd_cnt <= '0;
        end
        WAIT: begin
          wd_cnt <= wd_inc;
          // A response in the expiry cycle takes priority over the timeout.
          if (tgt_resp) begin
            resp_rdata <= out_wen ? 32'd0 : tgt_rdata;
            resp_error <= 1'b0;
          end else if (wd_expired) begin
            resp_rdata <= '0;
            resp_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_mmio_router.sv
// tb/tb_mem_mmio_router.sv - directed self-checking bench for mem_mmio_router
module tb_mem_mmio_router;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] out_addr;
  logic        out_wen;
  logic [31:0] out_wdata;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        dev_valid;
  logic        dev_ready = 1'b0;
  logic        dev_resp_valid = 1'b0;
  logic [31:0] dev_resp_rdata = '0;

  int errors = 0;
  int checks = 0;
  int mem_cnt = 0;
  int dev_cnt = 0;

  mem_mmio_router #(
    .ADDR_W  (32),
    .DEV_BASE(32'h1000_0000),
    .DEV_LAST(32'h1000_0FFF),
    .TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wen       (req_wen),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_error    (resp_error),
    .resp_rdata    (resp_rdata),
    .out_addr      (out_addr),
    .out_wen       (out_wen),
    .out_wdata     (out_wdata),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .dev_valid     (dev_valid),
    .dev_ready     (dev_ready),
    .dev_resp_valid(dev_resp_valid),
    .dev_resp_rdata(dev_resp_rdata)
  );

  always #5 clk = ~clk;

  // Cycles with a target valid high, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_valid) mem_cnt++;
    if (dev_valid) dev_cnt++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle (cycle T); returns in cycle T+1.
  task automatic send_req(input logic [31:0] a, input logic w, input logic [31:0] d);
    req_addr  = a;
    req_wen   = w;
    req_wdata = d;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if ({resp_valid, resp_error, mem_valid, dev_valid, out_wen} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {resp_valid, resp_error, mem_valid, dev_valid, out_wen}); end
    checks++; if ({resp_rdata, out_addr, out_wdata} !== 96'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {resp_rdata, out_addr, out_wdata}); end
    reset = 1'b0;
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_mem_read;
    int m0, d0;
    m0 = mem_cnt; d0 = dev_cnt;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_T got=%b exp=1", req_ready); end
    send_req(32'h0000_0100, 1'b0, 32'h0);
    checks++; if ({mem_valid, dev_valid} !== 2'b10) begin errors++; $display("FAIL rd_valid_T1 got=%b exp=10", {mem_valid, dev_valid}); end
    checks++; if (out_addr !== 32'h0000_0100) begin errors++; $display("FAIL rd_out_addr got=%h exp=00000100", out_addr); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++; if ({mem_valid, resp_valid} !== 2'b00) begin errors++; $display("FAIL rd_T2 got=%b exp=00", {mem_valid, resp_valid}); end
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
    step();
    mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
    checks++; if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rd_resp_T3 got=%b%b %h exp=10 deadbeef", resp_valid, resp_error, resp_rdata); end
    step();
    checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rd_T4 got=%b exp=01", {resp_valid, req_ready}); end
    checks++; if ((mem_cnt - m0) !== 1 || (dev_cnt - d0) !== 0) begin errors++; $display("FAIL rd_valid_counts got=%0d/%0d exp=1/0", mem_cnt - m0, dev_cnt - d0); end
  endtask

  task automatic test_routing;
    logic [31:0] addrs [4] = '{32'h0FFF_FFFC, 32'h1000_0000, 32'h1000_0FFC, 32'h1000_1000};
    logic        exp_dev [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send_req(addrs[i], 1'b0, 32'h0);
      checks++; if ({mem_valid, dev_valid} !== {~exp_dev[i], exp_dev[i]}) begin errors++; $display("FAIL route_%0d addr=%h got=%b exp=%b", i, addrs[i], {mem_valid, dev_valid}, {~exp_dev[i], exp_dev[i]}); end
      mem_ready = 1'b1; dev_ready = 1'b1;
      step();
      mem_ready = 1'b0; dev_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hAAAA_0000 + i;
      dev_resp_valid = 1'b1; dev_resp_rdata = 32'hBBBB_0000 + i;
      step();
      mem_resp_valid = 1'b0; dev_resp_valid = 1'b0;
      checks++; if (resp_rdata !== (exp_dev[i] ? 32'hBBBB_0000 + i : 32'hAAAA_0000 + i)) begin errors++; $display("FAIL route_data_%0d got=%h", i, resp_rdata); end
      step();
    end
  endtask

  task automatic test_dev_write;
    int d0, m0;
    d0 = dev_cnt; m0 = mem_cnt;
    send_req(32'h1000_0004, 1'b1, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({dev_valid, out_wen, out_wdata} !== {2'b11, 32'hCAFE_F00D}) begin errors++; $display("FAIL wr_hold_%0d got=%b%b %h exp=11 cafef00d", i, dev_valid, out_wen, out_wdata); end
      step();
    end
    dev_ready = 1'b1;
    step();
    dev_ready = 1'b0;
    checks++; if ((dev_cnt - d0) !== 6 || (mem_cnt - m0) !== 0) begin errors++; $display("FAIL wr_valid_cycles got=%0d/%0d exp=6/0", dev_cnt - d0, mem_cnt - m0); end
    step();
    dev_resp_valid = 1'b1; dev_resp_rdata = 32'h1234_5678;
    step();
    dev_resp_valid = 1'b0;
    checks++; if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 32'h0}) begin errors++; $display("FAIL wr_resp got=%b%b %h exp=10 00000000", resp_valid, resp_error, resp_rdata); end
    step();
  endtask

  task automatic test_timeout;
    send_req(32'h0000_0200, 1'b0, 32'h0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL to_early_%0d got=%b exp=0", k, resp_valid); end
      step();
    end
    checks++; if ({resp_valid, resp_error, resp_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL to_err got=%b%b %h exp=11 00000000", resp_valid, resp_error, resp_rdata); end
    step();
    send_req(32'h0000_0204, 1'b0, 32'h0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step(); step(); step();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55AA_55AA;
    step();
    mem_resp_valid = 1'b0;
    checks++; if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 32'h55AA_55AA}) begin errors++; $display("FAIL to_race got=%b%b %h exp=10 55aa55aa", resp_valid, resp_error, resp_rdata); end
    step();
  endtask

  task automatic test_spurious_and_reset;
    send_req(32'h0000_0300, 1'b0, 32'h0);
    mem_ready = 1'b1; dev_resp_valid = 1'b1; dev_resp_rdata = 32'hFFFF_FFFF;
    step();
    mem_ready = 1'b0;
    step();
    dev_resp_valid = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL spur_ignored got=%b exp=0", resp_valid); end
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0BAD_F00D;
    step();
    mem_resp_valid = 1'b0;
    checks++; if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 32'h0BAD_F00D}) begin errors++; $display("FAIL spur_resp got=%b%b %h exp=10 0badf00d", resp_valid, resp_error, resp_rdata); end
    step();
    send_req(32'h0000_0400, 1'b0, 32'h0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if ({req_ready, mem_valid, resp_valid} !== 3'b000) begin errors++; $display("FAIL rst_wait got=%b exp=000", {req_ready, mem_valid, resp_valid}); end
    step();
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h7777_7777;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    step();
    mem_resp_valid = 1'b0;
    checks++; if ({resp_valid, req_ready, resp_rdata} !== {2'b01, 32'h0}) begin errors++; $display("FAIL rst_late_resp got=%b%b %h exp=01 00000000", resp_valid, req_ready, resp_rdata); end
  endtask

  task automatic test_align;
    int m0, d0;
    m0 = mem_cnt; d0 = dev_cnt;
    send_req(32'h0000_0102, 1'b0, 32'h0);
`ifdef MMIO_ROUTER_ALIGN_CHECK_EN
    checks++; if ({resp_valid, resp_error, resp_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL align_err got=%b%b %h exp=11 00000000", resp_valid, resp_error, resp_rdata); end
    step();
    checks++; if ((mem_cnt - m0) !== 0 || (dev_cnt - d0) !== 0) begin errors++; $display("FAIL align_no_valid got=%0d/%0d exp=0/0", mem_cnt - m0, dev_cnt - d0); end
`else
    checks++; if ({mem_valid, dev_valid, out_addr} !== {2'b10, 32'h0000_0102}) begin errors++; $display("FAIL align_fwd got=%b%b %h exp=10 00000102", mem_valid, dev_valid, out_addr); end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0102;
    step();
    mem_resp_valid = 1'b0;
    checks++; if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 32'h0000_0102}) begin errors++; $display("FAIL align_resp got=%b%b %h exp=10 00000102", resp_valid, resp_error, resp_rdata); end
    step();
    checks++; if ((dev_cnt - d0) !== 0 || (mem_cnt - m0) !== 1) begin errors++; $display("FAIL align_counts got=%0d/%0d exp=1/0", mem_cnt - m0, dev_cnt - d0); end
`endif
  endtask

  task automatic test_back_to_back;
    int accepts, resps;
    accepts = 0; resps = 0;
    req_addr = 32'h0000_0500; req_wen = 1'b0; req_valid = 1'b1;
    mem_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_1111;
    for (int c = 0; c < 8; c++) begin
      if (req_ready) accepts++;
      if (resp_valid) resps++;
      step();
    end
    req_valid = 1'b0; mem_ready = 1'b0; mem_resp_valid = 1'b0;
    checks++; if (accepts !== 2 || resps !== 2) begin errors++; $display("FAIL b2b_rate got=%0d/%0d exp=2/2", accepts, resps); end
    checks++; if ({req_ready, resp_rdata} !== {1'b1, 32'h1111_1111}) begin errors++; $display("FAIL b2b_end got=%b %h exp=1 11111111", req_ready, resp_rdata); end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_routing();
    test_dev_write();
    test_timeout();
    test_spurious_and_reset();
    test_align();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
